// File: rtl/wb_mtimer.sv
// rtl/wb_mtimer.sv - Wishbone classic 64-bit machine timer with prescaler and compare interrupt
module wb_mtimer #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_ni,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_we_i,
    input  logic [DW/8-1:0] wb_sel_i,
    output logic            wb_ack_o,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            timer_irq_o
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] hi_shadow;
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic        en;
    logic        ie;

    logic        accept;
    logic        wr;
    logic        rd;
    logic [2:0]  adr;
    logic        tick;
    logic        match;
    logic [31:0] cur_word;
    logic [31:0] rdata;
    logic [31:0] wr_word;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[AW-1:3];
    assign adr        = wb_adr_i[2:0];
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr         = accept & wb_we_i;
    assign rd         = accept & ~wb_we_i;
    assign tick       = en && (pcnt == prescale);
    assign match      = (mtime >= mtimecmp);

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // cur_word is the true register content, used as the base for partial-lane writes
    always_comb begin
        cur_word = '0;
        case (adr)
            3'd0:    cur_word = mtime[31:0];
            3'd1:    cur_word = mtime[63:32];
            3'd2:    cur_word = mtimecmp[31:0];
            3'd3:    cur_word = mtimecmp[63:32];
            3'd4:    cur_word = {30'd0, ie, en};
            3'd5:    cur_word = {16'd0, prescale};
            default: cur_word = '0;
        endcase
    end

    always_comb begin
        rdata = cur_word;
        if (adr == 3'd1) rdata = hi_shadow;
        if (adr == 3'd6) rdata = {31'd0, match};
    end

    assign wr_word = merge_lanes(cur_word, wb_dat_i, wb_sel_i);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_ni) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            hi_shadow   <= '0;
            prescale    <= '0;
            pcnt        <= '0;
            en          <= 1'b0;
            ie          <= 1'b0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            timer_irq_o <= 1'b0;
        end else begin
            wb_ack_o    <= accept;
            wb_dat_o    <= accept ? rdata : '0;
            timer_irq_o <= ie & match;

            if (!en || (wr && adr == 3'd5) || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end

            // A bus write to either mtime half swallows that cycle's tick
            if (wr && adr == 3'd0) begin
                mtime[31:0] <= wr_word;
            end else if (wr && adr == 3'd1) begin
                mtime[63:32] <= wr_word;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (rd && adr == 3'd0) hi_shadow <= mtime[63:32];

            if (wr) begin
                case (adr)
                    3'd2: mtimecmp[31:0]  <= wr_word;
                    3'd3: mtimecmp[63:32] <= wr_word;
                    3'd4: begin
                        en <= wr_word[0];
                        ie <= wr_word[1];
                    end
                    3'd5: prescale <= wr_word[15:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/wb_mtimer.md
# wb_mtimer

Wishbone classic slave providing a RISC-V-style 64-bit machine timer (mtime/mtimecmp) with a programmable prescaler. It sits on a spare slave port of the SoC Wishbone crossbar, alongside boot ROM, SRAM, LED PWM and USB serial. It drives the VexRiscv `timerInterrupt` input directly. Software uses it for tick generation and timeouts without polling the USB core.

## Interface
- `AW`, default 30: Wishbone word-address width. Only `wb_adr_i[2:0]` is decoded; the crossbar has already selected this slave.
- `DW`, default 32: data width. Only 32 is supported.
- `wb_clk_i` in, 1: the single clock.
- `wb_reset_ni` in, 1: reset, synchronous and active-low.
- `wb_adr_i` in, AW: word address.
- `wb_dat_i` in, DW: write data.
- `wb_dat_o` out, DW: read data, valid while `wb_ack_o` is high.
- `wb_we_i` in, 1: write enable.
- `wb_sel_i` in, DW/8: byte-lane enables. Honoured on every writable register.
- `wb_ack_o` out, 1: single-cycle acknowledge.
- `wb_cyc_i`, `wb_stb_i` in, 1 each: classic bus-cycle strobes.
- `timer_irq_o` out, 1: registered, level-sensitive machine-timer interrupt.

## Operation
- Register map (word offset; reset value):
  - 0 MTIME_LO, rw; 0.
  - 1 MTIME_HI, rw; 0. Reads return the shadow register.
  - 2 MTIMECMP_LO, rw; 0xFFFFFFFF.
  - 3 MTIMECMP_HI, rw; 0xFFFFFFFF.
  - 4 CTRL, rw; 0. Bit0 EN (count enable), bit1 IE (interrupt enable). Other bits read 0.
  - 5 PRESCALE, rw; 0. Bits [15:0] hold the divisor P. Bits [31:16] read 0.
  - 6 STATUS, ro; 0. Bit0 = compare match (mtime >= mtimecmp), unmasked.
  - 7: reads 0, writes ignored, still acknowledged.
- Prescaler:
  - 16-bit counter `pcnt` runs only while EN=1.
  - A tick occurs when EN=1 and pcnt==P. On a tick, pcnt returns to 0 and mtime increments by 1.
  - mtime is 64 bits and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - pcnt clears when EN=0 and on any write to PRESCALE.
- mtime writes:
  - A write to MTIME_LO or MTIME_HI loads the byte-selected lanes of that half. The other half holds.
  - The tick in that cycle is suppressed: no increment and no carry. The prescaler itself still advances.
- Coherent 64-bit read:
  - Reading MTIME_LO returns the live low word and, in the same cycle, copies the live high word into `hi_shadow`.
  - Reading MTIME_HI returns `hi_shadow`.
  - `hi_shadow` resets to 0 and changes only on MTIME_LO reads.
- Interrupt:
  - `match` = unsigned 64-bit compare, mtime >= mtimecmp.
  - `timer_irq_o` <= IE & match, registered every cycle.
  - The interrupt is cleared only by raising mtimecmp, lowering mtime, or clearing IE.
- Bus cycle:
  - An access is accepted in a cycle with `cyc & stb & !ack`.
  - A write takes effect at that clock edge.
  - `wb_ack_o` is high for exactly the next cycle, and `wb_dat_o` is valid with it.
  - `wb_dat_o` is 0 when ack is low.
  - `wb_dat_o` reflects register contents at the accept edge, before that edge's update.
- Bus error is never signalled.

## Timing
- Reset values while `wb_reset_ni`=0: every register takes its listed value, pcnt=0, `wb_ack_o`=0, `wb_dat_o`=0, `timer_irq_o`=0.
- Reset asserted mid-transaction drops any pending ack. No write is performed in the reset cycle.
- Access latency: 1 cycle from accept to ack.
- Throughput: one access per 2 cycles. `stb` held continuously produces ack on alternate cycles.
- Tick period: P+1 cycles. The first tick comes P+1 cycles after the edge that sets EN.
- Interrupt latency:
  - `timer_irq_o` rises 1 cycle after the edge at which mtime first equals mtimecmp.
  - It falls 1 cycle after the edge of a write that removes the match.
- Simultaneous events:
  - A bus write to EN=0 in a tick cycle: the tick still occurs (EN is sampled before the write).
  - An MTIMECMP write and a match change in the same cycle: irq uses the post-edge values, one cycle later.

## Test plan
- Reset: hold `wb_reset_ni` low 3 cycles, release, read offsets 0–7 -> 0, 0, FFFFFFFF, FFFFFFFF, 0, 0, 0, 0. `timer_irq_o`=0 throughout.
- Prescaler: write PRESCALE=3, then CTRL=1. After 40 cycles, read MTIME_LO -> 10 (±1 for read latency). Every increment is exactly 4 cycles apart.
- Carry and snapshot:
  - Write MTIME_HI=0 and MTIME_LO=0xFFFFFFFE, P=0, EN=1.
  - Read LO at mtime=0x0_FFFFFFFF, then wait 5 cycles, then read HI -> LO=0xFFFFFFFF, HI=0 (shadow), not 1.
  - Repeat the LO read -> HI read now returns 1.
- Interrupt:
  - Set MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3, P=0, mtime=0.
  - `timer_irq_o` rises exactly 1 cycle after mtime reaches 20.
  - Write MTIMECMP_HI=1 -> irq low 1 cycle after the ack edge. STATUS bit0 reads 0.
- Byte lanes: write 0xAABBCCDD to PRESCALE with `sel`=4'b0010 -> reads 0x0000CC00. Write MTIME_LO with `sel`=0 -> no change, still acked.
- Back-to-back and reset: hold `cyc`/`stb` high for 8 cycles -> exactly 4 acks. Pull `wb_reset_ni` low in an ack-pending cycle with irq high -> next cycle ack=0, irq=0, and all registers are at reset values.
